// File: rtl/decoder_seq_pkg.sv
// Shared definitions for the decoder scan sequencer: FSM states, scan modes
// and default widths.
package decoder_seq_pkg;

  localparam int DEF_WIDTH   = 3;
  localparam int DEF_DWELL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_SINGLE = 2'b10;

endpackage

// File: rtl/decoder_scan_seq_dwell_timer.sv
// Dwell down-counter: loads a hold count, counts down on enable, and flags zero
// so the sequencer knows when the current code has been held long enough.
module dwell_timer
  import decoder_seq_pkg::*;
#(
  parameter int W = DEF_DWELL_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_enable,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load has priority so a reload on the advancing cycle is never lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/decoder_scan_seq.sv
// Scan sequencer that steps a decoder select code up, down or once through all
// values, holding each code for a configurable number of ready cycles.
module decoder_scan_seq
  import decoder_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [1:0]         i_mode,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic               i_code_ready,
  output logic [WIDTH-1:0]   o_code,
  output logic               o_code_valid,
  output logic               o_busy,
  output logic               o_wrap,
  output logic               o_done
);

  localparam logic [WIDTH-1:0] CODE_MAX = '1;

  state_e             r_state;
  logic [1:0]         r_mode;
  logic [DWELL_W-1:0] r_dwell;
  logic [WIDTH-1:0]   r_code;
  logic               r_valid;
  logic               r_busy;
  logic               r_wrap;
  logic               r_done;

  logic               w_start_go;
  logic               w_step;
  logic               w_zero;
  logic               w_adv;
  logic               w_down;
  logic               w_single;
  logic               w_at_end;
  logic [WIDTH-1:0]   w_code_next;
  logic               w_tmr_load;
  logic [DWELL_W-1:0] w_tmr_val;

  // Stop dominates both a coincident start in IDLE and an advance in RUN.
  assign w_start_go  = (r_state == IDLE) && i_start && !i_stop;
  assign w_step      = (r_state == RUN) && i_code_ready && !i_stop;
  assign w_adv       = w_step && w_zero;

  // Reserved mode 11 falls through to up-wrap since it is neither down nor single.
  assign w_down      = (r_mode == MODE_DOWN);
  assign w_single    = (r_mode == MODE_SINGLE);
  assign w_at_end    = w_down ? (r_code == '0) : (r_code == CODE_MAX);
  assign w_code_next = w_down ? (r_code - 1'b1) : (r_code + 1'b1);

  assign w_tmr_load  = w_start_go || w_adv;
  assign w_tmr_val   = w_start_go ? i_dwell : r_dwell;

  dwell_timer #(
    .W(DWELL_W)
  ) u_dwell_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_enable   (w_step),
    .i_load_val (w_tmr_val),
    .o_zero     (w_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_mode  <= '0;
      r_dwell <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_go) begin
            r_mode  <= i_mode;
            r_dwell <= i_dwell;
            r_code  <= (i_mode == MODE_DOWN) ? CODE_MAX : '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (i_stop) begin
            r_state <= IDLE;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_adv) begin
            if (w_single && w_at_end) begin
              r_state <= DONE;
              r_code  <= '0;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_code <= w_code_next;
              r_wrap <= w_at_end;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_code  <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_code       = r_code;
  assign o_code_valid = r_valid;
  assign o_busy       = r_busy;
  assign o_wrap       = r_wrap;
  assign o_done       = r_done;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Table-driven scoreboard bench for decoder_scan_seq, with a 3-to-8 decoder on
// the code output and hand-written reset sequences.
module tb_decoder_scan_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [3:0] dwell;
  logic       code_ready;
  logic [2:0] code;
  logic       code_valid;
  logic       busy;
  logic       wrap;
  logic       done;

  decoder_scan_seq #(
    .WIDTH   (3),
    .DWELL_W (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_stop       (stop),
    .i_mode       (mode),
    .i_dwell      (dwell),
    .i_code_ready (code_ready),
    .o_code       (code),
    .o_code_valid (code_valid),
    .o_busy       (busy),
    .o_wrap       (wrap),
    .o_done       (done)
  );

  // 3-to-8 decoder fed by x/y/z, x being the code MSB.
  logic       dec_x, dec_y, dec_z;
  logic [7:0] dec_out;
  assign dec_x = code[2];
  assign dec_y = code[1];
  assign dec_z = code[0];
  always_comb begin
    dec_out = '0;
    for (int i = 0; i < 8; i++) dec_out[i] = ({dec_x, dec_y, dec_z} == 3'(i));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       start, stop;
    logic [1:0] mode;
    logic [3:0] dwell;
    logic       ready;
    logic [2:0] code;
    logic       valid, busy, wrap, done;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input string tag, input logic st, input logic sp,
                     input logic [1:0] md, input logic [3:0] dw, input logic rdy,
                     input logic [2:0] c, input logic v, input logic b,
                     input logic w, input logic d);
    vec_t r;
    r.tag = tag; r.start = st; r.stop = sp; r.mode = md; r.dwell = dw; r.ready = rdy;
    r.code = c; r.valid = v; r.busy = b; r.wrap = w; r.done = d;
    tbl.push_back(r);
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if ({code, code_valid, busy, wrap, done} !== 7'b0) begin
      n_err++;
      $display("FAIL %s: got code=%0d v=%0b b=%0b w=%0b d=%0b, expected all zero",
               tag, code, code_valid, busy, wrap, done);
    end
  endtask

  // Drive one cycle of stimulus at a falling edge, then compare at the next one.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    logic [7:0] exp_dec;
    start = v.start; stop = v.stop; mode = v.mode; dwell = v.dwell; code_ready = v.ready;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({code, code_valid, busy, wrap, done} !== {e.code, e.valid, e.busy, e.wrap, e.done}) begin
      n_err++;
      $display("FAIL %s[%0d]: got code=%0d v=%0b b=%0b w=%0b d=%0b, expected code=%0d v=%0b b=%0b w=%0b d=%0b",
               e.tag, idx, code, code_valid, busy, wrap, done, e.code, e.valid, e.busy, e.wrap, e.done);
    end else begin
      $display("ok   %s[%0d]: code=%0d v=%0b b=%0b w=%0b d=%0b",
               e.tag, idx, code, code_valid, busy, wrap, done);
    end
    if (e.valid) begin
      exp_dec = 8'b1;
      exp_dec = exp_dec << e.code;
      n_cmp++;
      if (dec_out !== exp_dec) begin
        n_err++;
        $display("FAIL onehot %s[%0d]: got %b, expected %b", e.tag, idx, dec_out, exp_dec);
      end
    end
  endtask

  task automatic step1(input string tag, input logic st, input logic sp,
                       input logic [1:0] md, input logic [3:0] dw, input logic rdy,
                       input logic [2:0] c, input logic v, input logic b,
                       input logic w, input logic d);
    vec_t r;
    r.tag = tag; r.start = st; r.stop = sp; r.mode = md; r.dwell = dw; r.ready = rdy;
    r.code = c; r.valid = v; r.busy = b; r.wrap = w; r.done = d;
    step(r, 0);
  endtask

  initial begin
    // Up-wrap, dwell 0: 0..7 then wrap on the 9th valid cycle, then stop.
    add("upwrap", 1, 0, 2'd0, 4'd0, 1, 3'd0, 1, 1, 0, 0);
    for (int c = 1; c < 8; c++) add("upwrap", 0, 0, 2'd0, 4'd0, 1, 3'(c), 1, 1, 0, 0);
    add("upwrap", 0, 0, 2'd0, 4'd0, 1, 3'd0, 1, 1, 1, 0);
    add("upwrap", 0, 0, 2'd0, 4'd0, 1, 3'd1, 1, 1, 0, 0);
    add("upwrap", 0, 1, 2'd0, 4'd0, 1, 3'd0, 0, 0, 0, 0);
    add("upwrap", 0, 0, 2'd0, 4'd0, 1, 3'd0, 0, 0, 0, 0);
    // Single pass, dwell 2: each code held 3 cycles, then done; start in DONE ignored.
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 3; k++)
        add("single", (c == 0 && k == 0), 0, 2'd2, 4'd2, 1, 3'(c), 1, 1, 0, 0);
    add("single", 0, 0, 2'd2, 4'd2, 1, 3'd0, 0, 0, 0, 1);
    add("single", 1, 0, 2'd2, 4'd2, 1, 3'd0, 0, 0, 0, 0);
    add("single", 0, 0, 2'd2, 4'd2, 1, 3'd0, 0, 0, 0, 0);
    // Down-wrap, dwell 1, ready 1,0,1,1; mode/dwell inputs changed mid-run.
    add("down", 1, 0, 2'd1, 4'd1, 0, 3'd7, 1, 1, 0, 0);
    add("down", 0, 0, 2'd1, 4'd1, 1, 3'd7, 1, 1, 0, 0);
    add("down", 0, 0, 2'd1, 4'd1, 0, 3'd7, 1, 1, 0, 0);
    add("down", 0, 0, 2'd1, 4'd1, 1, 3'd6, 1, 1, 0, 0);
    add("down", 0, 0, 2'd1, 4'd1, 1, 3'd6, 1, 1, 0, 0);
    for (int c = 5; c >= 0; c--) begin
      add("down", 0, 0, 2'd0, 4'd0, 1, 3'(c), 1, 1, 0, 0);
      add("down", 0, 0, 2'd0, 4'd0, 1, 3'(c), 1, 1, 0, 0);
    end
    add("down", 0, 0, 2'd0, 4'd0, 1, 3'd7, 1, 1, 1, 0);
    add("down", 0, 1, 2'd0, 4'd0, 1, 3'd0, 0, 0, 0, 0);
    add("down", 0, 0, 2'd0, 4'd0, 1, 3'd0, 0, 0, 0, 0);
    // Stop at code 5 coinciding with an advance.
    add("stop5", 1, 0, 2'd0, 4'd0, 1, 3'd0, 1, 1, 0, 0);
    for (int c = 1; c < 6; c++) add("stop5", 0, 0, 2'd0, 4'd0, 1, 3'(c), 1, 1, 0, 0);
    add("stop5", 0, 1, 2'd0, 4'd0, 1, 3'd0, 0, 0, 0, 0);
    add("stop5", 0, 0, 2'd0, 4'd0, 1, 3'd0, 0, 0, 0, 0);
    // Start+stop in IDLE, then reserved mode 3 with a start during RUN.
    add("ststp", 1, 1, 2'd0, 4'd0, 1, 3'd0, 0, 0, 0, 0);
    add("ststp", 0, 0, 2'd0, 4'd0, 1, 3'd0, 0, 0, 0, 0);
    add("mode3", 1, 0, 2'd3, 4'd0, 1, 3'd0, 1, 1, 0, 0);
    for (int c = 1; c < 8; c++) add("mode3", (c == 4), 0, 2'd3, 4'd0, 1, 3'(c), 1, 1, 0, 0);
    add("mode3", 0, 0, 2'd3, 4'd0, 1, 3'd0, 1, 1, 1, 0);
    add("mode3", 0, 1, 2'd3, 4'd0, 1, 3'd0, 0, 0, 0, 0);

    rst_n = 1'b0; start = 0; stop = 0; mode = 0; dwell = 0; code_ready = 0;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // Asynchronous reset in the middle of a clock period during RUN.
    step1("prerst", 1, 0, 2'd0, 4'd3, 1, 3'd0, 1, 1, 0, 0);
    step1("prerst", 0, 0, 2'd0, 4'd3, 1, 3'd0, 1, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    check_zero("rst_held");
    rst_n = 1'b1;
    step1("postrst", 0, 0, 2'd0, 4'd0, 1, 3'd0, 0, 0, 0, 0);
    step1("postrst", 1, 0, 2'd0, 4'd0, 1, 3'd0, 1, 1, 0, 0);
    step1("postrst", 0, 0, 2'd0, 4'd0, 1, 3'd1, 1, 1, 0, 0);
    step1("postrst", 0, 1, 2'd0, 4'd0, 1, 3'd0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decoder_scan_seq.md
DECODER_SCAN_SEQ -- requirements
Module: decoder_scan_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the code width that drives the 3-to-8 decoder inputs x/y/z.
REQ-002 The block SHALL have parameter DWELL_W, default 4, giving the width of the dwell configuration.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  a single-cycle request to begin a scan.
REQ-006 stop  input  1  a single-cycle request to abort a scan.
REQ-007 mode  input  2  scan mode: 00 up-wrap, 01 down-wrap, 10 single pass up, 11 reserved and treated as 00.
REQ-008 dwell  input  DWELL_W  extra hold cycles per code.
REQ-009 code_ready  input  1  the downstream stage accepts the current code.
REQ-010 code  output  WIDTH  the decoder select code, with bit WIDTH-1 mapped to x.
REQ-011 code_valid  output  1  code is meaningful.
REQ-012 busy  output  1  a scan is in progress.
REQ-013 wrap  output  1  a one-cycle pulse on each wrap-around.
REQ-014 done  output  1  a one-cycle pulse at the end of a single pass.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 In IDLE, outputs SHALL be: code=0, code_valid=0, busy=0, wrap=0, done=0.
REQ-017 When start=1 in IDLE, the block SHALL, on the next edge:
- capture mode and dwell into internal registers;
- load code with 0 (modes up-wrap and single pass) or 2^WIDTH-1 (mode down-wrap);
- load the dwell counter with the captured dwell value;
- enter RUN.
REQ-018 Consequently, code_valid=1 and busy=1 SHALL appear one cycle after start.
REQ-019 Changes to mode or dwell during RUN SHALL be ignored.
REQ-020 In RUN, code_valid=1 and busy=1.
- When code_ready=1 and the dwell counter is non-zero, the counter SHALL decrement.
- When code_ready=1 and the dwell counter is 0, the code SHALL advance and the counter SHALL reload.
- When code_ready=0, both code and the counter SHALL freeze.
REQ-021 Each code SHALL therefore be presented for exactly dwell+1 ready cycles; dwell=0 SHALL advance the code on every ready cycle.
REQ-022 Advance arithmetic SHALL be modulo 2^WIDTH:
- up-wrap: a step from 2^WIDTH-1 to 0 SHALL assert wrap for one cycle, coincident with code=0;
- down-wrap: a step from 0 to 2^WIDTH-1 SHALL assert wrap likewise.
REQ-023 In single-pass mode, an advance from 2^WIDTH-1 SHALL enter DONE instead of wrapping, and wrap SHALL NOT assert.
REQ-024 In DONE, the block SHALL drive done=1, code_valid=0, busy=0 and code=0 for one cycle, then return to IDLE.
REQ-025 When stop=1 in RUN, the block SHALL enter IDLE on the next edge, with no done and no wrap pulse.
REQ-026 If stop and an advance coincide in the same cycle, stop SHALL win.
REQ-027 When start and stop are both 1 in IDLE, the block SHALL remain in IDLE.
REQ-028 start in RUN or DONE SHALL be ignored; it is not queued.
REQ-029 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-030 rst=0 SHALL immediately force IDLE and zero all outputs, the dwell counter and the captured mode/dwell registers, independent of clk.
REQ-031 Reset deassertion SHALL take effect at the next rising clk.
REQ-032 A reset asserted mid-scan SHALL abandon the scan with no done pulse.

Structure
REQ-033 A shared package decoder_seq_pkg SHALL hold:
- the FSM state enumeration (IDLE, RUN, DONE);
- the mode codes MODE_UP, MODE_DOWN and MODE_SINGLE;
- the default WIDTH and DWELL_W constants.
REQ-034 The dwell counter SHALL be one sub-module, dwell_timer, with ports: load, enable, load value, and a zero flag.
REQ-035 The code register, FSM and wrap/done pulse logic SHALL reside in decoder_scan_seq; the target size is 120-250 RTL lines.

Verification
REQ-036 The bench SHALL connect code to a 3-to-8 decoder instance and check one-hot correctness every cycle in which code_valid=1.
REQ-037 Scenario: mode=00, dwell=0, ready=1, start pulse -> code runs 0..7 on consecutive cycles; wrap=1 with code=0 on the 9th valid cycle.
REQ-038 Scenario: mode=10, dwell=2 -> each code is held 3 cycles; after code 7, done=1 for one cycle; valid first asserts 1 cycle after start.
REQ-039 Scenario: mode=01, dwell=1, ready toggled 1,0,1,1 -> code starts at 7, freezes whenever ready=0, and steps to 6 only after 2 ready cycles.
REQ-040 Scenario: stop asserted when code=5 in mode 00 -> next cycle code=0, valid=0, busy=0, no wrap and no done.
REQ-041 Scenario: rst pulled low mid-clock-period during RUN -> outputs zero before the next edge; a start after reset release begins at code=0.
REQ-042 Scenario: start and stop asserted together in IDLE -> the block stays in IDLE; start asserted during RUN -> no restart and no code glitch.
